core_regfile: RTL and testbench
===============================

Name: core_regfile

Overview:
- General-purpose register file: the consumer end of the execute-stage writeback interface (wb, wb_addr, wb_data).
- Serves two combinational read ports to the decode stage and tracks in-flight destinations with a busy scoreboard, so decode can stall on read-after-write hazards.
- Sits between the ID stage (read, issue) and the EX stage (writeback).

Parameters:
- DATA_W, 32, register/data width (matches data_t).
- ADDR_W, 5, register address width (matches reg_addr_t).
- NREGS, 32, number of registers, equal to 2**ADDR_W; r0 is hardwired zero.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- wb  input  1  writeback enable from EX stage.
- wb_addr  input  ADDR_W  writeback destination register.
- wb_data  input  DATA_W  writeback value.
- ra_addr  input  ADDR_W  read port A address.
- rb_addr  input  ADDR_W  read port B address.
- ra_data  output  DATA_W  read port A data.
- rb_data  output  DATA_W  read port B data.
- ra_busy  output  1  port A register has a pending write.
- rb_busy  output  1  port B register has a pending write.
- issue_en  input  1  ID issues an instruction that will write issue_addr.
- issue_addr  input  ADDR_W  destination of the issued instruction.
- sb_flush  input  1  pipeline flush; clears all busy bits.
- busy_cnt  output  ADDR_W+1  number of registers currently busy.

Behaviour:
- Reset (rst low, asynchronous): all registers = 0, all busy bits = 0, busy_cnt = 0. Read outputs follow the cleared array: ra_data = rb_data = 0, ra_busy = rb_busy = 0.
- Write: at posedge clk, if wb=1 and wb_addr!=0, then reg[wb_addr] <= wb_data. Writes to r0 are discarded.
- Read: combinational from the array.
  - ra_data = reg[ra_addr]; rb_data = reg[rb_addr].
  - Address 0 always returns 0.
  - Without bypass, a write is visible one cycle after it is presented.
- Scoreboard: busy[i] next-state, evaluated in priority order:
  1. sb_flush=1 -> 0 for all i; issue is ignored in the flush cycle.
  2. issue_en=1 and issue_addr==i and i!=0 -> 1. Set wins over a same-cycle clear of the same register.
  3. wb=1 and wb_addr==i -> 0.
  4. Otherwise hold.
- busy[0] is constantly 0.
- ra_busy = busy[ra_addr] (registered state); rb_busy likewise. issue_en in the current cycle does not affect busy outputs until the next cycle.
- busy_cnt: registered popcount of next-state busy, updated every cycle, range 0..NREGS-1.
- Writeback to a register that is not busy is legal: data is written and busy stays 0.
- Repeated issue to an already-busy register leaves it busy; a single wb clears it. The scoreboard is not a counter per register.
- ra_addr==rb_addr: both ports return identical data and busy.

Optional Feature:
- Macro: CORE_REGFILE_BYPASS_EN.
- Defined: write-to-read bypass.
  - If wb=1, wb_addr!=0 and ra_addr==wb_addr, then ra_data = wb_data and ra_busy = busy[ra_addr] & ~(wb & wb_addr==ra_addr), all in the same cycle. rb is identical.
  - Saves one stall cycle on RAW hazards.
- Undefined: no bypass. Read data and busy reflect registered state only; a consumer stalls until the cycle after writeback.

Test Plan:
- Reset mid-operation: write 0xDEADBEEF to r5, set busy r5, then pulse rst low mid-cycle -> ra_data(r5)=0, ra_busy=0, busy_cnt=0 immediately, without waiting for clk.
- r0 protection: wb=1, wb_addr=0, wb_data=0xFFFFFFFF; issue_en to r0 -> ra_addr=0 gives ra_data=0, ra_busy=0, busy_cnt=0.
- RAW stall: issue r3 in cycle 0; wb r3=0x1234 in cycle 3 -> ra_busy(r3)=1 in cycles 1-3.
  - Without bypass: ra_data=0x1234 and ra_busy=0 in cycle 4.
  - With bypass: both hold in cycle 3.
- Simultaneous set/clear: r7 busy; same cycle wb r7 and issue r7 -> r7 written, busy stays 1, busy_cnt unchanged.
- Flush: issue r1, r2, r3 (busy_cnt=3), then sb_flush=1 with issue_en r4 -> all busy 0, busy_cnt=0 next cycle, r4 not busy.
- Dual port: ra_addr=rb_addr=r9 after wb r9=0xA5A5A5A5 -> both ports return 0xA5A5A5A5; write r31 then read r31 -> no address wrap.

Source files
------------

// File: rtl/core_regfile_if.sv
// core_regfile_if: connects the ID stage (reads, issue) and the EX stage
// (writeback) to the general-purpose register file.
// The master side drives writeback, read addresses, issue and flush.
// The slave side, the register file, returns read data, busy flags and the busy count.
interface core_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              wb;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic              ra_busy;
  logic              rb_busy;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_addr;
  logic              sb_flush;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output wb, wb_addr, wb_data, ra_addr, rb_addr, issue_en, issue_addr, sb_flush,
    input  ra_data, rb_data, ra_busy, rb_busy, busy_cnt
  );

  modport slave (
    input  wb, wb_addr, wb_data, ra_addr, rb_addr, issue_en, issue_addr, sb_flush,
    output ra_data, rb_data, ra_busy, rb_busy, busy_cnt
  );

endinterface

// File: rtl/core_regfile.sv
// core_regfile: general-purpose register file with two combinational read
// ports and a busy scoreboard for read-after-write hazard detection.
// Register r0 is hardwired to zero and is never marked busy.
// Optional build macro CORE_REGFILE_BYPASS_EN enables write-to-read bypass.
// With the bypass, a writeback is visible on a read port in the same cycle,
// and the busy flag for that port drops in the same cycle.
module core_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 2**ADDR_W
) (
  input logic          clk,
  input logic          rst,
  core_regfile_if.slave bus
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic [ADDR_W:0]   cnt_next;
  logic [ADDR_W:0]   busy_cnt_q;

  // Register array: writeback stores data; writes to r0 are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (bus.wb && bus.wb_addr != '0) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Scoreboard next state. A flush overrides everything. Otherwise the clear
  // is applied before the set, so an issue wins over a writeback to the same register.
  always_comb begin
    busy_next = busy;
    if (bus.sb_flush) begin
      busy_next = '0;
    end else begin
      if (bus.wb) busy_next[bus.wb_addr] = 1'b0;
      if (bus.issue_en && bus.issue_addr != '0) busy_next[bus.issue_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Popcount of the next busy state, registered together with the busy bits.
  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt_next = cnt_next + {{ADDR_W{1'b0}}, busy_next[i]};
    end
  end

  // Busy bits and busy count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy       <= busy_next;
      busy_cnt_q <= cnt_next;
    end
  end

  assign bus.busy_cnt = busy_cnt_q;

`ifdef CORE_REGFILE_BYPASS_EN
  // Read ports with bypass: a writeback in flight is forwarded to a matching
  // nonzero read address, and that port's busy flag is suppressed.
  always_comb begin
    bus.ra_data = (bus.ra_addr == '0) ? '0 : regs[bus.ra_addr];
    bus.rb_data = (bus.rb_addr == '0) ? '0 : regs[bus.rb_addr];
    bus.ra_busy = busy[bus.ra_addr];
    bus.rb_busy = busy[bus.rb_addr];
    if (bus.wb && bus.wb_addr != '0 && bus.ra_addr == bus.wb_addr) bus.ra_data = bus.wb_data;
    if (bus.wb && bus.wb_addr != '0 && bus.rb_addr == bus.wb_addr) bus.rb_data = bus.wb_data;
    if (bus.wb && bus.wb_addr == bus.ra_addr) bus.ra_busy = 1'b0;
    if (bus.wb && bus.wb_addr == bus.rb_addr) bus.rb_busy = 1'b0;
  end
`else
  // Read ports without bypass: data and busy flags come from registered state only.
  always_comb begin
    bus.ra_data = (bus.ra_addr == '0) ? '0 : regs[bus.ra_addr];
    bus.rb_data = (bus.rb_addr == '0) ? '0 : regs[bus.rb_addr];
    bus.ra_busy = busy[bus.ra_addr];
    bus.rb_busy = busy[bus.rb_addr];
  end
`endif

endmodule

// File: tb/tb_core_regfile.sv
// tb_core_regfile: scoreboard testbench for core_regfile.
// Each applied cycle pushes the expected read-port and busy-count values to a
// queue. The values are popped and compared once the DUT outputs settle.
module tb_core_regfile;

  logic clk;
  logic rst;

  core_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  core_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] ra_d;
    logic [31:0] rb_d;
    logic        ra_b;
    logic        rb_b;
    logic [5:0]  cnt;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic [5:0]  m_cnt;
  int          vectors = 0;
  int          miscompares = 0;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] popCount(input logic [31:0] v);
    logic [5:0] c = '0;
    for (int i = 0; i < 32; i++) c = c + {5'd0, v[i]};
    return c;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
    m_cnt  = '0;
  endtask

  // Drive one cycle of stimulus. The expected outputs are pushed to the queue
  // from the model, popped and compared at the negedge, and the model is
  // advanced at the next posedge.
  task automatic applyStimulus(input logic wb, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra, input logic [4:0] rb,
                               input logic ie, input logic [4:0] ia, input logic fl);
    exp_t        e;
    exp_t        got;
    logic [31:0] nb;
    bus.wb = wb; bus.wb_addr = wa; bus.wb_data = wd;
    bus.ra_addr = ra; bus.rb_addr = rb;
    bus.issue_en = ie; bus.issue_addr = ia; bus.sb_flush = fl;
    e.ra_d = (ra == 0) ? 32'd0 : m_regs[ra];
    e.rb_d = (rb == 0) ? 32'd0 : m_regs[rb];
    e.ra_b = m_busy[ra];
    e.rb_b = m_busy[rb];
    e.cnt  = m_cnt;
`ifdef CORE_REGFILE_BYPASS_EN
    if (wb && wa != 0 && ra == wa) begin e.ra_d = wd; e.ra_b = 1'b0; end
    if (wb && wa != 0 && rb == wa) begin e.rb_d = wd; e.rb_b = 1'b0; end
`endif
    sbq.push_back(e);
    @(negedge clk);
    got = sbq.pop_front();
    checkOutput("ra_data", bus.ra_data, got.ra_d);
    checkOutput("rb_data", bus.rb_data, got.rb_d);
    checkOutput("ra_busy", {31'd0, bus.ra_busy}, {31'd0, got.ra_b});
    checkOutput("rb_busy", {31'd0, bus.rb_busy}, {31'd0, got.rb_b});
    checkOutput("busy_cnt", {26'd0, bus.busy_cnt}, {26'd0, got.cnt});
    @(posedge clk);
    if (fl) begin
      nb = '0;
    end else begin
      nb = m_busy;
      if (wb) nb[wa] = 1'b0;
      if (ie && ia != 0) nb[ia] = 1'b1;
    end
    nb[0] = 1'b0;
    if (wb && wa != 0) m_regs[wa] = wd;
    m_busy = nb;
    m_cnt  = popCount(nb);
    #1;
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    applyStimulus(1'b0, 5'd0, 32'd0, ra, rb, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    bus.wb = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.ra_addr = 5'd1; bus.rb_addr = 5'd2;
    bus.issue_en = 1'b0; bus.issue_addr = '0; bus.sb_flush = 1'b0;
    modelClear();
    #2;
    checkOutput("reset_ra_data", bus.ra_data, 32'd0);
    checkOutput("reset_rb_busy", {31'd0, bus.rb_busy}, 32'd0);
    checkOutput("reset_busy_cnt", {26'd0, bus.busy_cnt}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    $display("[TB] r0 protection");
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    idle(5'd0, 5'd0);
    checkOutput("r0_busy_cnt", {26'd0, bus.busy_cnt}, 32'd0);

    $display("[TB] RAW stall on r3");
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0);
    idle(5'd3, 5'd3);
    idle(5'd3, 5'd3);
    applyStimulus(1'b1, 5'd3, 32'h0000_1234, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    idle(5'd3, 5'd0);
    checkOutput("raw_data_after_wb", bus.ra_data, 32'h0000_1234);
    checkOutput("raw_busy_after_wb", {31'd0, bus.ra_busy}, 32'd0);

    $display("[TB] simultaneous set and clear on r7");
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0);
    applyStimulus(1'b1, 5'd7, 32'h0000_0077, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0);
    idle(5'd7, 5'd0);
    checkOutput("setclr_busy", {31'd0, bus.ra_busy}, 32'd1);
    checkOutput("setclr_cnt", {26'd0, bus.busy_cnt}, 32'd1);
    applyStimulus(1'b1, 5'd7, 32'h0000_0078, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);

    $display("[TB] flush");
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b1, 5'd1, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, 1'b1, 5'd2, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd1, 5'd3, 1'b1, 5'd3, 1'b0);
    checkOutput("flush_pre_cnt", {26'd0, bus.busy_cnt}, 32'd3);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd1, 5'd4, 1'b1, 5'd4, 1'b1);
    idle(5'd4, 5'd1);
    checkOutput("flush_cnt", {26'd0, bus.busy_cnt}, 32'd0);
    checkOutput("flush_r4_busy", {31'd0, bus.ra_busy}, 32'd0);

    $display("[TB] dual port and top register");
    applyStimulus(1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0);
    idle(5'd9, 5'd9);
    checkOutput("dual_ra", bus.ra_data, 32'hA5A5_A5A5);
    checkOutput("dual_rb", bus.rb_data, 32'hA5A5_A5A5);
    applyStimulus(1'b1, 5'd31, 32'h3131_0031, 5'd31, 5'd0, 1'b0, 5'd0, 1'b0);
    idle(5'd31, 5'd0);
    checkOutput("r31_data", bus.ra_data, 32'h3131_0031);
    checkOutput("r31_r0_data", bus.rb_data, 32'd0);

    $display("[TB] random traffic");
    for (int n = 0; n < 60; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                    5'($urandom), 5'($urandom), 1'($urandom_range(0, 1)), 5'($urandom),
                    ($urandom_range(0, 15) == 0));
    end

    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0);
    idle(5'd5, 5'd5);
    checkOutput("pre_rst_data", bus.ra_data, 32'hDEAD_BEEF);
    checkOutput("pre_rst_busy", {31'd0, bus.ra_busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_data", bus.ra_data, 32'd0);
    checkOutput("async_rst_busy", {31'd0, bus.ra_busy}, 32'd0);
    checkOutput("async_rst_cnt", {26'd0, bus.busy_cnt}, 32'd0);
    modelClear();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle(5'd5, 5'd31);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
